// File: rtl/fir_stream_pkg.sv
// Shared types and defaults for the FIR stream controller.
// ADDR_W is limited to 13 because the core's sample address bus is 13 bits wide.
package fir_stream_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} state_e;
   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 12;
   localparam int ILE_W      = 14;
   localparam int CORE_AW    = 13;
endpackage

// File: rtl/fir_stream_ctrl_if.sv
// Stream and FIR-core signal bundle; slave is the controller side, master the environment.
interface fir_stream_ctrl_if #(parameter int DATA_W = fir_stream_pkg::DATA_W_DEF);
   import fir_stream_pkg::*;
   logic                s_valid, s_ready, s_last;
   logic [DATA_W-1:0]   s_data;
   logic                fir_start, fir_pracuje, fir_done, fir_wyj_wr;
   logic [ILE_W-1:0]    fir_ile_probek;
   logic [CORE_AW-1:0]  fir_a_probki;
   logic [DATA_W-1:0]   fir_probka, fir_wynik;
   logic                m_valid, m_ready, m_last;
   logic [DATA_W-1:0]   m_data;
   logic                busy, err_overflow;

   modport slave (
      input  s_valid, s_data, s_last, fir_pracuje, fir_done, fir_a_probki,
             fir_wyj_wr, fir_wynik, m_ready,
      output s_ready, fir_start, fir_ile_probek, fir_probka, m_valid, m_data,
             m_last, busy, err_overflow
   );
   modport master (
      output s_valid, s_data, s_last, fir_pracuje, fir_done, fir_a_probki,
             fir_wyj_wr, fir_wynik, m_ready,
      input  s_ready, fir_start, fir_ile_probek, fir_probka, m_valid, m_data,
             m_last, busy, err_overflow
   );
endinterface

// File: rtl/fir_buf_ram.sv
// DEPTH x DATA_W buffer: synchronous write, asynchronous read.
module fir_buf_ram #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/fir_stream_ctrl.sv
// Loads a sample block, kicks the FIR core, captures its results and streams them out.
module fir_stream_ctrl
   import fir_stream_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   fir_stream_ctrl_if.slave  bus
);
   localparam logic [ADDR_W:0] ONE  = 1;
   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] LAST = FULL - ONE;

   state_e            state_q;
   logic [ADDR_W:0]   in_cnt_q, wr_cnt_q, rd_ptr_q, wr_cnt_d;
   logic              start_q, ovf_q;
   logic              s_fire, m_fire, r_take;
   logic [DATA_W-1:0] rbuf_rdata;
   logic              unused_ok;

   assign bus.s_ready        = (state_q == IDLE || state_q == LOAD) && (in_cnt_q < FULL);
   assign bus.m_valid        = (state_q == DRAIN) && (rd_ptr_q < wr_cnt_q);
   assign bus.m_last         = (state_q == DRAIN) && (rd_ptr_q == wr_cnt_q - ONE);
   assign bus.m_data         = rbuf_rdata;
   assign bus.fir_start      = start_q;
   assign bus.fir_ile_probek = (state_q inside {START, RUN, DRAIN}) ? ILE_W'(in_cnt_q) : '0;
   assign bus.busy           = (state_q != IDLE);
   assign bus.err_overflow   = ovf_q;

   assign s_fire   = bus.s_valid && bus.s_ready;
   assign m_fire   = bus.m_valid && bus.m_ready;
   assign r_take   = (state_q == RUN) && bus.fir_wyj_wr && (wr_cnt_q < in_cnt_q);
   // Post-capture count, so a result arriving with done still selects DRAIN.
   assign wr_cnt_d = r_take ? wr_cnt_q + ONE : wr_cnt_q;

   generate
      if (ADDR_W < CORE_AW) begin : g_hi
         assign unused_ok = ^{bus.fir_pracuje, bus.fir_a_probki[CORE_AW-1:ADDR_W]};
      end else begin : g_nohi
         assign unused_ok = bus.fir_pracuje;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         in_cnt_q <= '0;
         wr_cnt_q <= '0;
         rd_ptr_q <= '0;
         start_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            IDLE, LOAD: begin
               if (s_fire) begin
                  in_cnt_q <= in_cnt_q + ONE;
                  state_q  <= (bus.s_last || in_cnt_q == LAST) ? START : LOAD;
               end
            end
            START: begin
               start_q  <= 1'b1;
               wr_cnt_q <= '0;
               ovf_q    <= 1'b0;
               state_q  <= RUN;
            end
            RUN: begin
               wr_cnt_q <= wr_cnt_d;
               if (bus.fir_wyj_wr && !r_take) ovf_q <= 1'b1;
               if (bus.fir_done) begin
                  if (wr_cnt_d == '0) begin
                     state_q  <= IDLE;
                     in_cnt_q <= '0;
                     rd_ptr_q <= '0;
                  end else begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (m_fire) begin
                  rd_ptr_q <= rd_ptr_q + ONE;
                  if (bus.m_last) begin
                     state_q  <= IDLE;
                     in_cnt_q <= '0;
                     rd_ptr_q <= '0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   fir_buf_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_sbuf (
      .clk     (clk),
      .we_i    (s_fire),
      .waddr_i (in_cnt_q[ADDR_W-1:0]),
      .wdata_i (bus.s_data),
      .raddr_i (bus.fir_a_probki[ADDR_W-1:0]),
      .rdata_o (bus.fir_probka)
   );

   fir_buf_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rbuf (
      .clk     (clk),
      .we_i    (r_take),
      .waddr_i (wr_cnt_q[ADDR_W-1:0]),
      .wdata_i (bus.fir_wynik),
      .raddr_i (rd_ptr_q[ADDR_W-1:0]),
      .rdata_o (rbuf_rdata)
   );
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_fir_stream_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fir_stream_ctrl_if #(.DATA_W(16)) bus ();
   fir_stream_ctrl_if #(.DATA_W(16)) bus2 ();

   fir_stream_ctrl #(.ADDR_W(12), .DATA_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   fir_stream_ctrl #(.ADDR_W(3), .DATA_W(16)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus2));

   int checks = 0, errors = 0, timeouts = 0, nb = 0, stall_viol = 0;
   logic [15:0] got_d [16];
   logic        got_l [16];

   task automatic push(input logic [15:0] d, input logic l);
      int g = 0;
      bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l;
      while (!bus.s_ready && g < 20) begin @(negedge clk); g++; end
      if (g >= 20) timeouts++;
      @(negedge clk);
      bus.s_valid = 1'b0; bus.s_last = 1'b0;
   endtask

   task automatic core_wr(input logic [15:0] d);
      bus.fir_wyj_wr = 1'b1; bus.fir_wynik = d;
      @(negedge clk);
      bus.fir_wyj_wr = 1'b0;
   endtask

   task automatic core_done();
      bus.fir_done = 1'b1;
      @(negedge clk);
      bus.fir_done = 1'b0;
   endtask

   // Collects output beats until the m_last handshake; bp stalls every other cycle.
   task automatic drain(input bit bp);
      int cyc = 0;
      bit fin = 1'b0, stalled = 1'b0;
      logic [15:0] held = '0;
      nb = 0; stall_viol = 0;
      for (int i = 0; i < 16; i++) begin got_d[i] = '0; got_l[i] = 1'b0; end
      while (!fin && cyc < 60) begin
         bus.m_ready = bp ? cyc[0] : 1'b1;
         if (bus.m_valid) begin
            if (stalled && bus.m_data !== held) stall_viol++;
            if (bus.m_ready) begin
               if (nb < 16) begin got_d[nb] = bus.m_data; got_l[nb] = bus.m_last; end
               nb++; fin = bus.m_last; stalled = 1'b0;
            end else begin
               stalled = 1'b1; held = bus.m_data;
            end
         end
         @(negedge clk); cyc++;
      end
      bus.m_ready = 1'b0;
      if (!fin) timeouts++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", bus.s_ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if ({bus.fir_start, bus.m_valid, bus.m_last, bus.err_overflow} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {bus.fir_start, bus.m_valid, bus.m_last, bus.err_overflow}); end
      checks++; if (bus.fir_ile_probek !== 14'd0) begin errors++; $display("FAIL reset_ile got %0d exp 0", bus.fir_ile_probek); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      push(16'h1, 1'b0); push(16'h2, 1'b0); push(16'h3, 1'b0); push(16'h4, 1'b1);
      checks++; if (bus.fir_start !== 1'b0) begin errors++; $display("FAIL basic_start_early got %b exp 0", bus.fir_start); end
      @(negedge clk);
      checks++; if (bus.fir_start !== 1'b1) begin errors++; $display("FAIL basic_start_pulse got %b exp 1", bus.fir_start); end
      checks++; if (bus.fir_ile_probek !== 14'd4) begin errors++; $display("FAIL basic_ile got %0d exp 4", bus.fir_ile_probek); end
      @(negedge clk);
      checks++; if (bus.fir_start !== 1'b0) begin errors++; $display("FAIL basic_start_width got %b exp 0", bus.fir_start); end
      bus.fir_a_probki = 13'd2; #1;
      checks++; if (bus.fir_probka !== 16'h0003) begin errors++; $display("FAIL basic_probka got %h exp 0003", bus.fir_probka); end
      core_wr(16'h10); core_wr(16'h20); core_wr(16'h30); core_wr(16'h40); core_done();
      drain(1'b0);
      checks++; if (nb !== 4) begin errors++; $display("FAIL basic_beats got %0d exp 4", nb); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (got_d[i] !== 16'(16'h10 * (i + 1)) || got_l[i] !== (i == 3)) begin errors++; $display("FAIL basic_beat%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], 16'(16'h10 * (i + 1)), (i == 3)); end
      end
      checks++; if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b m_valid=%b exp 0/0", bus.busy, bus.m_valid); end
   endtask

   task automatic test_backpressure();
      push(16'h1, 1'b0); push(16'h2, 1'b0); push(16'h3, 1'b0); push(16'h4, 1'b1);
      @(negedge clk); @(negedge clk);
      core_wr(16'h10); core_wr(16'h20); core_wr(16'h30); core_wr(16'h40); core_done();
      drain(1'b1);
      checks++; if (nb !== 4) begin errors++; $display("FAIL bp_beats got %0d exp 4", nb); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (got_d[i] !== 16'(16'h10 * (i + 1)) || got_l[i] !== (i == 3)) begin errors++; $display("FAIL bp_beat%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], 16'(16'h10 * (i + 1)), (i == 3)); end
      end
      checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", stall_viol); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", bus.busy); end
   endtask

   task automatic test_full_buffer();
      int acc = 0;
      bus2.s_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bus2.s_data = 16'h100 + 16'(acc);
         if (bus2.s_ready) acc++;
         @(negedge clk);
      end
      bus2.s_valid = 1'b0;
      checks++; if (acc !== 8) begin errors++; $display("FAIL full_accepted got %0d exp 8", acc); end
      checks++; if (bus2.s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready got %b exp 0", bus2.s_ready); end
      checks++; if (bus2.fir_ile_probek !== 14'd8) begin errors++; $display("FAIL full_ile got %0d exp 8", bus2.fir_ile_probek); end
      bus2.fir_a_probki = 13'd7; #1;
      checks++; if (bus2.fir_probka !== 16'h0107) begin errors++; $display("FAIL full_probka got %h exp 0107", bus2.fir_probka); end
      bus2.fir_done = 1'b1; @(negedge clk); bus2.fir_done = 1'b0;
      checks++; if (bus2.busy !== 1'b0 || bus2.s_ready !== 1'b1) begin errors++; $display("FAIL full_idle got busy=%b s_ready=%b exp 0/1", bus2.busy, bus2.s_ready); end
   endtask

   task automatic test_overflow();
      push(16'hA, 1'b0); push(16'hB, 1'b1);
      @(negedge clk); @(negedge clk);
      checks++; if (bus.err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", bus.err_overflow); end
      core_wr(16'h100); core_wr(16'h200); core_wr(16'h300);
      checks++; if (bus.err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bus.err_overflow); end
      core_done();
      drain(1'b0);
      checks++; if (nb !== 2) begin errors++; $display("FAIL ovf_beats got %0d exp 2", nb); end
      checks++; if (got_d[0] !== 16'h100 || got_d[1] !== 16'h200 || got_l[0] !== 1'b0 || got_l[1] !== 1'b1) begin errors++; $display("FAIL ovf_data got %h,%h last %b%b exp 0100,0200 last 01", got_d[0], got_d[1], got_l[0], got_l[1]); end
      checks++; if (bus.err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.err_overflow); end
   endtask

   task automatic test_short();
      push(16'h21, 1'b0); push(16'h22, 1'b0); push(16'h23, 1'b1);
      checks++; if (bus.err_overflow !== 1'b1) begin errors++; $display("FAIL short_ovf_hold got %b exp 1", bus.err_overflow); end
      @(negedge clk);
      checks++; if (bus.err_overflow !== 1'b0) begin errors++; $display("FAIL short_ovf_clear got %b exp 0", bus.err_overflow); end
      core_wr(16'h77); core_done();
      drain(1'b0);
      checks++; if (nb !== 1 || got_d[0] !== 16'h77 || got_l[0] !== 1'b1) begin errors++; $display("FAIL short_beat got n=%0d %h/%b exp n=1 0077/1", nb, got_d[0], got_l[0]); end
   endtask

   task automatic test_zero();
      push(16'h5, 1'b0); push(16'h6, 1'b1);
      @(negedge clk); @(negedge clk);
      core_done();
      checks++; if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin errors++; $display("FAIL zero_idle got busy=%b m_valid=%b s_ready=%b exp 0/0/1", bus.busy, bus.m_valid, bus.s_ready); end
   endtask

   task automatic test_reset_mid_run();
      push(16'h1, 1'b0); push(16'h2, 1'b1);
      @(negedge clk); @(negedge clk);
      core_wr(16'h99);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", bus.busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_async got s_ready=%b busy=%b m_valid=%b exp 1/0/0", bus.s_ready, bus.busy, bus.m_valid); end
      checks++; if (bus.fir_ile_probek !== 14'd0) begin errors++; $display("FAIL rst_ile got %0d exp 0", bus.fir_ile_probek); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(16'h55, 1'b1);
      @(negedge clk);
      checks++; if (bus.fir_start !== 1'b1 || bus.fir_ile_probek !== 14'd1) begin errors++; $display("FAIL rst_single got start=%b ile=%0d exp 1/1", bus.fir_start, bus.fir_ile_probek); end
      bus.fir_a_probki = 13'd0; #1;
      checks++; if (bus.fir_probka !== 16'h0055) begin errors++; $display("FAIL rst_probka got %h exp 0055", bus.fir_probka); end
      core_done();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_end_idle got %b exp 0", bus.busy); end
   endtask

   initial begin
      bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.fir_pracuje = 1'b0;
      bus.fir_done = 1'b0; bus.fir_a_probki = '0; bus.fir_wyj_wr = 1'b0; bus.fir_wynik = '0;
      bus.m_ready = 1'b0;
      bus2.s_valid = 1'b0; bus2.s_data = '0; bus2.s_last = 1'b0; bus2.fir_pracuje = 1'b0;
      bus2.fir_done = 1'b0; bus2.fir_a_probki = '0; bus2.fir_wyj_wr = 1'b0; bus2.fir_wynik = '0;
      bus2.m_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_full_buffer();
      test_overflow();
      test_short();
      test_zero();
      test_reset_mid_run();
      checks++; if (timeouts !== 0) begin errors++; $display("FAIL handshake_timeouts got %0d exp 0", timeouts); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fir_stream_ctrl.md
Name: fir_stream_ctrl

Overview:
- Host-side counterpart of the FIR core.
- Accepts input samples on a valid/ready stream and holds them in an internal sample buffer, which the FIR core reads by address.
- Pulses the FIR start, captures every result the core writes into an internal result buffer, then streams the results out on a valid/ready stream.
- Sits between the system stream fabric and the FIR core: it owns both the sample RAM and the result RAM of the filter.

Parameters:
- ADDR_W, 12: buffer address width; DEPTH = 2**ADDR_W entries in each buffer.
- DATA_W, 16: sample and result width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample ready
- s_data  in  DATA_W  input sample
- s_last  in  1  last sample of block
- fir_start  out  1  one-cycle start pulse to FIR core
- fir_ile_probek  out  14  number of samples loaded (N)
- fir_pracuje  in  1  core busy
- fir_done  in  1  core finished
- fir_a_probki  in  13  core sample read address; only bits [ADDR_W-1:0] are used
- fir_probka  out  DATA_W  sample at fir_a_probki, asynchronous read, same cycle
- fir_wyj_wr  in  1  core result write strobe
- fir_wynik  in  DATA_W  core result data
- m_valid  out  1  output result valid
- m_ready  in  1  output result ready
- m_data  out  DATA_W  output result
- m_last  out  1  final result of block
- busy  out  1  state != IDLE
- err_overflow  out  1  sticky: a result strobe arrived after N results were stored

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; in_cnt, wr_cnt, rd_ptr = 0.
  - Outputs: s_ready=1, fir_start=0, fir_ile_probek=0, m_valid=0, m_last=0, busy=0, err_overflow=0.
  - Buffer contents are not reset.
  - Reset asserted mid-operation aborts immediately; there is no pending handshake.
- States: IDLE, LOAD, START, RUN, DRAIN.
- IDLE / LOAD:
  - s_ready=1 while in_cnt < DEPTH.
  - An accepted beat (s_valid & s_ready) writes s_data to sbuf[in_cnt] and increments in_cnt.
  - The first accepted beat moves IDLE→LOAD.
  - An accepted beat with s_last, or the beat that makes in_cnt==DEPTH, moves to START on the next cycle.
  - A beat with s_last as the first beat gives a single-sample block (N=1).
- START:
  - fir_start=1 for exactly one cycle.
  - fir_ile_probek=N, held until return to IDLE.
  - s_ready=0; clear wr_cnt and err_overflow; next state RUN.
- RUN:
  - Each fir_wyj_wr with wr_cnt<N writes rbuf[wr_cnt]=fir_wynik and increments wr_cnt.
  - fir_wyj_wr with wr_cnt==N: data dropped, err_overflow←1.
  - fir_done sampled high moves to DRAIN, or to IDLE if wr_cnt==0.
  - A fir_wyj_wr in the same cycle as fir_done is still captured.
  - fir_done is ignored outside RUN.
- DRAIN:
  - m_valid=1 while rd_ptr<wr_cnt; m_data=rbuf[rd_ptr], combinational.
  - m_last = (rd_ptr==wr_cnt-1).
  - Handshake m_valid & m_ready increments rd_ptr.
  - m_data is held stable while m_valid & !m_ready.
  - The accepted beat with m_last moves to IDLE next cycle and clears in_cnt and rd_ptr.
  - fir_ile_probek returns to 0.
  - err_overflow holds until the next START.
- Short block: if the core writes fewer than N results, only wr_cnt results are drained.
- Readback: fir_probka is always sbuf[fir_a_probki[ADDR_W-1:0]], in every state.
- Width rules:
  - in_cnt, wr_cnt and rd_ptr are ADDR_W+1 bits.
  - fir_ile_probek is in_cnt zero-extended to 14 bits.
  - ADDR_W must be ≤13.

Decomposition:
- Package fir_stream_pkg holds the state enum typedef (IDLE, LOAD, START, RUN, DRAIN) and the DATA_W default constant.
- One sub-module, fir_buf_ram: DEPTH×DATA_W, one synchronous write port, one asynchronous read port. It is instantiated twice, as sample buffer and result buffer.

Test Plan:
- Basic block:
  - Stimulus: stream 4 samples 0x0001..0x0004, s_last on the 4th.
  - Required: fir_start pulses once, 2 cycles after the last beat; fir_ile_probek=4; fir_probka at address 2 = 0x0003.
  - Then: core model writes results 0x0010..0x0040 and pulses done; m_data emits 0x0010,0x0020,0x0030,0x0040, m_last on the 4th; busy drops one cycle later.
- Backpressure:
  - Stimulus: same block with m_ready toggled every other cycle.
  - Required: exactly 4 beats, no duplicates or drops, m_data stable while stalled.
- Full buffer:
  - Stimulus: ADDR_W=3, stream 10 samples with no s_last.
  - Required: s_ready drops after 8 accepted beats; fir_ile_probek=8.
- Overflow:
  - Stimulus: N=2, core writes 3 results.
  - Required: only the first 2 are drained; err_overflow=1 until the next START.
- Short result / zero result:
  - Stimulus: N=3, core writes 1 result then done.
  - Required: 1 beat with m_last=1.
  - Stimulus: core writes 0 results then done.
  - Required: return to IDLE with no m_valid.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 asynchronously during RUN.
  - Required: s_ready=1, busy=0, m_valid=0 immediately.
  - Then: a new 1-sample block with s_last on the first beat gives fir_ile_probek=1.
